dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage and a slow line-wide data memory. It answers hits combinationally with no stall. On a miss it asserts `cpu_stall_o` and runs an optional write-back followed by a line refill over a req/ack memory port. The pipeline freezes all stage registers while `cpu_stall_o` is high.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; must be a power of two, 2..256.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-low.
- `cpu_addr_i`, input, 32: byte address from the MEM stage ALU result.
- `cpu_wdata_i`, input, 32: store data.
- `cpu_read_i`, input, 1: load request.
- `cpu_write_i`, input, 1: store request.
- `cpu_rdata_o`, output, 32: load data; valid when a read hits; 0 otherwise.
- `cpu_stall_o`, output, 1: the current access is not complete; the pipeline holds.
- `mem_req_o`, output, 1: memory transfer request.
- `mem_we_o`, output, 1: 1 = line write (write-back), 0 = line read (refill).
- `mem_addr_o`, output, 32: line-aligned address; bits [3:0] = 0.
- `mem_wdata_o`, output, 128: victim line data; word 0 is in bits [31:0].
- `mem_rdata_i`, input, 128: refill line data; same word order as `mem_wdata_o`.
- `mem_ack_i`, input, 1: transfer complete; `mem_rdata_i` is valid in the ack cycle.

## Operation
- **Address split:**
  - bits [1:0] are ignored;
  - bits [3:2] select the word;
  - bits [4+IW-1:4] are the index, where IW = log2(LINES);
  - the remaining upper bits are the tag.
- **Per-line state:** valid bit, dirty bit, tag, four 32-bit words.
- **Access:** an access exists when `cpu_read_i | cpu_write_i`. If both are high, the access is a write; `cpu_rdata_o` is still driven on a hit.
- **Hit:** the line is valid and its tag matches, with FSM in IDLE.
  - Read hit: `cpu_rdata_o` = selected word, same cycle.
  - Write hit: the word is updated at the clock edge and the dirty bit is set.
- **Miss:** `cpu_stall_o` = 1 combinationally in the detection cycle.
- **FSM states:**
  - IDLE: on a miss, go to WRITEBACK if the victim is valid and dirty, else go to ALLOCATE.
  - WRITEBACK: `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`={victim tag, index, 4'b0}, `mem_wdata_o`=victim line. On `mem_ack_i`, clear the dirty bit and go to ALLOCATE.
  - ALLOCATE: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={cpu tag, index, 4'b0}. On `mem_ack_i`, write `mem_rdata_i` into the line, set valid, clear dirty, update the tag, and go to IDLE.
  - On return to IDLE the access re-evaluates as a hit. A store merges at that point and sets dirty.
- **Memory handshake:**
  - The memory port is held stable while `mem_req_o` is high and `mem_ack_i` is low.
  - Each ack completes exactly one transfer.
  - `mem_ack_i` is ignored while `mem_req_o` is low.
  - `mem_req_o` may stay high from WRITEBACK straight into ALLOCATE; the address and `mem_we_o` change at that edge.
- **Stall:** `cpu_stall_o` = access & (FSM != IDLE | miss). It is 0 when there is no access.
- **CPU inputs during a miss:** the CPU address and data are held by the stalled pipeline. Changes to them during a miss are not supported.

## Timing
- **Reset values:** all valid and dirty bits = 0, FSM = IDLE, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0. `cpu_rdata_o` and `cpu_stall_o` are 0 unless an access is present.
- **Reset mid-operation:** reset during WRITEBACK or ALLOCATE drops `mem_req_o` immediately. Dirty data is discarded.
- **Hit latency:** 0 stall cycles.
- **Clean miss:** stall cycles = 1 + N, where N = cycles from request to ack (≥1). The minimum is 2.
- **Dirty miss:** stall cycles = 1 + N_wb + N_alloc. The minimum is 3.
- **Index wrap-around:** addresses 16·LINES bytes apart alias to the same line and evict each other.

## Configuration
- `DCACHE_STATS_EN`:
  - When defined, the block adds outputs `hit_cnt_o` [31:0] and `miss_cnt_o` [31:0]. Both reset to 0 and wrap modulo 2^32.
  - `miss_cnt_o` increments on each IDLE→WRITEBACK or IDLE→ALLOCATE transition.
  - `hit_cnt_o` increments in each cycle where an access completes (stall low) and the access did not miss.
  - When not defined, neither the ports nor the counter logic exist.

## Test plan
- **Cold read, clean miss:** after reset, read 0x0000_0040; memory acks 3 cycles after req with line {0x4,0x3,0x2,0x1} in word order 0..3 → one ALLOCATE req to addr 0x40, 4 stall cycles, then `cpu_rdata_o`=0x1. A following read of 0x44 returns 0x2 with no stall.
- **Write hit then dirty eviction:**
  - write 0xDEADBEEF to 0x48 → 0 stall, line dirty;
  - then read 0x48+16·LINES → WRITEBACK to 0x40 with `mem_wdata_o` word 2 = 0xDEADBEEF;
  - then ALLOCATE to 0x40+16·LINES.
- **Write miss allocate:** write 0x12345678 to clean-miss address 0x100 → refill, then the merge. A subsequent read of 0x100 returns 0x12345678 and the line is dirty.
- **Handshake hold:** hold `mem_ack_i` low for 10 cycles → `mem_req_o`, `mem_addr_o` and `mem_we_o` stable throughout, `cpu_stall_o`=1 throughout.
- **Reset mid-refill:** assert `rst_i`=0 during ALLOCATE → `mem_req_o`=0 within the same cycle. After release, a read of the same address misses again.
- **Stats (`DCACHE_STATS_EN`):** sequence miss, hit, hit, dirty miss → `miss_cnt_o`=2, `hit_cnt_o`=2.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller, 16B lines.
// Optional hit/miss counters via `define DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
`ifdef DCACHE_STATS_EN
  input  logic         mem_ack_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`else
  input  logic         mem_ack_i
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [127:0]     line_q [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    word;
  logic          access, tag_hit, hit, miss;
  logic          unused_addr;

  assign idx  = cpu_addr_i[4 +: IW];
  assign tag  = cpu_addr_i[31 -: TW];
  assign word = cpu_addr_i[3:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign access  = cpu_read_i | cpu_write_i;
  assign tag_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign hit     = access && tag_hit && (state_q == IDLE);
  assign miss    = access && !tag_hit && (state_q == IDLE);

  assign cpu_stall_o = access && ((state_q != IDLE) || miss);
  assign cpu_rdata_o = (hit && cpu_read_i)
                     ? line_q[idx][{word, 5'b0} +: 32] : '0;

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        if (miss)
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx], idx, 4'b0};
        mem_wdata_o = line_q[idx];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, idx, 4'b0};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WRITEBACK && mem_ack_i) begin
        dirty_q[idx] <= 1'b0;
      end else if (state_q == ALLOCATE && mem_ack_i) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (hit && cpu_write_i) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Payload arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (state_q == ALLOCATE && mem_ack_i) begin
      line_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= tag;
    end else if (hit && cpu_write_i) begin
      line_q[idx][{word, 5'b0} +: 32] <= cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  // Remembers that the pending access missed, so its completion is no hit.
  logic missed_q;
  logic start_miss;

  assign start_miss = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      missed_q   <= 1'b0;
    end else begin
      if (start_miss)
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if (access && !cpu_stall_o && !missed_q)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (start_miss)
        missed_q <= 1'b1;
      else if (access && !cpu_stall_o)
        missed_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl (LINES=16); memory model serves
// requests with a per-test ack latency.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_read_i  (cpu_read),
    .cpu_write_i (cpu_write),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
`ifdef DCACHE_STATS_EN
    .mem_ack_i   (mem_ack),
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`else
    .mem_ack_i   (mem_ack)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  int           stalls, wb_reqs, al_reqs, unstable;
  logic [31:0]  wb_addr, al_addr;
  logic [127:0] wb_data;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1 of the miss-detection cycle; returns at
  // negedge+1 of the first non-stalled cycle.
  task automatic serve(input int lwb, input int lal,
                       input logic [127:0] line);
    int cnt;
    logic [31:0] pa;
    logic pw;
    cnt = 0; pa = '0; pw = 1'b0;
    stalls = 0; wb_reqs = 0; al_reqs = 0; unstable = 0;
    for (int c = 0; c < 200 && stall; c++) begin
      stalls++;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt == 0) begin
          pa = mem_addr;
          pw = mem_we;
          if (mem_we) begin
            wb_reqs++;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
          end else begin
            al_reqs++;
            al_addr = mem_addr;
          end
        end else if (mem_addr !== pa || mem_we !== pw || !stall) begin
          unstable++;
        end
        cnt++;
        if (cnt == (pw ? lwb : lal)) begin
          mem_ack   = 1'b1;
          mem_rdata = line;
          cnt = 0;
        end
      end
      @(negedge clk); #1;
    end
    mem_ack = 1'b0;
    chk("miss_done", stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    cpu_read = 1'b0; cpu_write = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    wb_addr = '0; al_addr = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 128'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
`ifdef DCACHE_STATS_EN
    chk("rst_hits", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b1;

    // cold read, clean miss
    cpu_addr = 32'h40; cpu_read = 1'b1;
    #1;
    chk("cold_stall", stall, 1'b1);
    chk("cold_noreq", mem_req, 1'b0);
    serve(1, 3, 128'h00000004_00000003_00000002_00000001);
    chk("cold_stalls", stalls, 4);
    chk("cold_alreqs", al_reqs, 1);
    chk("cold_wbreqs", wb_reqs, 0);
    chk("cold_aladdr", al_addr, 32'h40);
    chk("cold_rdata", cpu_rdata, 32'h1);
    @(negedge clk);
    cpu_addr = 32'h44;
    #1;
    chk("hit44_stall", stall, 1'b0);
    chk("hit44_rdata", cpu_rdata, 32'h2);

    // write hit, then dirty eviction by alias
    @(negedge clk);
    cpu_addr = 32'h48; cpu_read = 1'b0; cpu_write = 1'b1;
    cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("wr48_stall", stall, 1'b0);
    chk("wr48_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    cpu_write = 1'b0; cpu_read = 1'b1;
    #1;
    chk("rd48_rdata", cpu_rdata, 32'hDEADBEEF);
    @(negedge clk);
    cpu_addr = 32'h148;
    #1;
    chk("alias_stall", stall, 1'b1);
    serve(1, 1, 128'h000000B4_000000B3_000000B2_000000B1);
    chk("alias_stalls", stalls, 3);
    chk("alias_wbreqs", wb_reqs, 1);
    chk("alias_wbaddr", wb_addr, 32'h40);
    chk("alias_wbdata", wb_data,
        128'h00000004_DEADBEEF_00000002_00000001);
    chk("alias_aladdr", al_addr, 32'h140);
    chk("alias_rdata", cpu_rdata, 32'hB3);

    // write miss allocate + merge
    @(negedge clk);
    cpu_addr = 32'h100; cpu_read = 1'b0; cpu_write = 1'b1;
    cpu_wdata = 32'h12345678;
    #1;
    serve(1, 2, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    chk("wmiss_stalls", stalls, 3);
    chk("wmiss_wbreqs", wb_reqs, 0);
    chk("wmiss_aladdr", al_addr, 32'h100);
    @(negedge clk);
    cpu_write = 1'b0; cpu_read = 1'b1;
    #1;
    chk("wmiss_rdata", cpu_rdata, 32'h12345678);

    // dirty eviction with a long-held refill ack
    @(negedge clk);
    cpu_addr = 32'h200;
    #1;
    serve(1, 11, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
    chk("hold_stalls", stalls, 13);
    chk("hold_unstable", unstable, 0);
    chk("hold_wbaddr", wb_addr, 32'h100);
    chk("hold_wbdata", wb_data,
        128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_12345678);
    chk("hold_aladdr", al_addr, 32'h200);
    chk("hold_rdata", cpu_rdata, 32'hD0D0D0D0);

    // reset in the middle of a refill
    @(negedge clk);
    cpu_addr = 32'h300;
    #1;
    chk("rmid_stall", stall, 1'b1);
    @(negedge clk);
    #1;
    chk("rmid_req", mem_req, 1'b1);
    chk("rmid_reqaddr", mem_addr, 32'h300);
    rst_i = 1'b0;
    #1;
    chk("rmid_dropreq", mem_req, 1'b0);
    chk("rmid_dropaddr", mem_addr, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rmid_remiss", stall, 1'b1);
    serve(1, 2, 128'h55555553_55555552_55555551_55555550);
    chk("rmid_stalls", stalls, 3);
    chk("rmid_aladdr", al_addr, 32'h300);
    chk("rmid_rdata", cpu_rdata, 32'h55555550);

    // miss (above), hit, hit, dirty miss
    @(negedge clk);
    cpu_addr = 32'h304;
    #1;
    chk("seq_hit1", cpu_rdata, 32'h55555551);
    @(negedge clk);
    cpu_addr = 32'h308; cpu_read = 1'b0; cpu_write = 1'b1;
    cpu_wdata = 32'hCAFEF00D;
    #1;
    chk("seq_hit2_stall", stall, 1'b0);
    @(negedge clk);
    cpu_addr = 32'h400; cpu_read = 1'b1; cpu_write = 1'b0;
    #1;
    serve(1, 1, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0);
    chk("seq_stalls", stalls, 3);
    chk("seq_wbaddr", wb_addr, 32'h300);
    chk("seq_wbdata", wb_data,
        128'h55555553_CAFEF00D_55555551_55555550);
    chk("seq_rdata", cpu_rdata, 32'hE0E0E0E0);
`ifdef DCACHE_STATS_EN
    chk("stats_miss", miss_cnt, 32'd2);
    chk("stats_hit", hit_cnt, 32'd2);
`endif
    @(negedge clk);
    cpu_read = 1'b0;
    #1;
    chk("idle_stall", stall, 1'b0);
    chk("idle_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    #1;
`ifdef DCACHE_STATS_EN
    chk("stats_miss_end", miss_cnt, 32'd2);
    chk("stats_hit_end", hit_cnt, 32'd2);
`endif
    chk("idle_req", mem_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
